ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//   Iterative RV32M/RV64M multiply/divide unit for the Execute stage, next to the combinational ALU.
//   Accepts one op per start pulse and computes N bits per cycle; busy stalls IF/ID/EX.
//   Returns result plus rd tag on a one-cycle done pulse.
//   Honours the stage freeze (dbg) and a pipeline flush.
// PARAMETERS
//   XLEN           32  operand/result width (32 or 64)
//   BITS_PER_CYCLE 1   quotient/multiplier bits retired per cycle; 1, 2 or 4; must divide XLEN
//   ITER = XLEN/BITS_PER_CYCLE (derived localparam)
// PORTS
//   clk     in   1     system clock
//   Rst     in   1     synchronous reset, active-high
//   dbg     in   1     freeze: hold all state and outputs
//   flush   in   1     abort in-flight op (branch/jump redirect)
//   start   in   1     launch op; sampled only in IDLE
//   op      in   3     funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   a       in   XLEN  forwarded rs1 operand
//   b       in   XLEN  forwarded rs2 operand
//   rd_in   in   5     destination register tag
//   busy    out  1     op in flight; pipeline must stall
//   done    out  1     one-cycle pulse: result/rd_out valid
//   result  out  XLEN  result; held until next done
//   rd_out  out  5     tag of the completed op; held with result
// BEHAVIOUR
//   Reset: FSM=IDLE, busy=0, done=0, result=0, rd_out=0, counter=0. Rst mid-op discards the op.
//   Priority each cycle: Rst > dbg > flush > start.
//   FSM IDLE -> RUN -> FIN -> IDLE:
//   - IDLE: start&!flush latches op, rd_in, |a|, |b| and result sign; goes to RUN with count=ITER, busy=1.
//   - RUN: one step per cycle; count decrements; at count==1 goes to FIN.
//   - FIN: result with sign fix registered; done=1, busy=0; returns to IDLE.
//   Timing: start in cycle 0 gives busy in cycles 1..ITER and done in cycle ITER+1.
//   Back-to-back: start accepted in the done cycle only if the FSM is already IDLE, so next start is at ITER+2.
//   MUL: 2*XLEN magnitude product by shift-add.
//   - MUL returns the low XLEN bits.
//   - MULH/MULHSU/MULHU return the high XLEN bits after two's-complement negate when the sign is negative.
//   - Signedness per op: MULH s*s, MULHSU a signed / b unsigned, MULHU u*u.
//   DIV: restoring divide on magnitudes.
//   - Quotient is negative iff the operand signs differ.
//   - Remainder takes the sign of a.
//   Early-out (no RUN state, done in cycle 1, busy never 1):
//   - b==0: quotient = all ones, remainder = a.
//   - Signed overflow (a == MIN, b == -1): quotient = MIN, remainder = 0.
//   dbg=1: counter, datapath regs and outputs frozen. A done pulse pending in FIN is delayed, not lost.
//   flush=1 in RUN/FIN: go to IDLE next cycle; no done; busy=0 next cycle; result/rd_out keep old values.
//   flush together with start in IDLE: start is ignored.
//   start while busy: ignored (the pipeline never issues one).
// CONFIGURATION
//   MDU_REUSE_EN defined:
//   - Keep the last full-length divide's quotient, remainder, operands, signedness and a valid bit.
//   - A DIV/REM (or DIVU/REMU) pair matching a, b and signedness completes in 1 cycle (done at cycle 1, busy=0).
//   - Valid bit cleared by Rst, by flush of a divide, and by any completed MUL-class op.
//   MDU_REUSE_EN undefined: no reuse storage; every non-early-out op takes full latency.
// TESTING (XLEN=32, BITS_PER_CYCLE=1)
//   MUL a=7, b=0xFFFFFFFD -> done at cycle 33, result 0xFFFFFFEB; busy high cycles 1..32.
//   MULH a=b=0x80000000 -> 0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=-1, b=2 -> 0xFFFFFFFF.
//   DIVU 100/7 -> 14 and REMU -> 2. DIV -100/7 -> -14 (0xFFFFFFF2) and REM -> -2 (0xFFFFFFFE).
//   DIV x/0 -> 0xFFFFFFFF at cycle 1. REM 5/0 -> 5.
//   DIV 0x80000000/-1 -> 0x80000000, REM -> 0; both at cycle 1.
//   flush at cycle 10 of a DIV -> busy=0 at 11, no done, result unchanged.
//   dbg held cycles 5..9 -> done at cycle 38.
//   Rst at cycle 20 -> all outputs 0 next cycle.
//   DIV 100/7 then REM 100/7 -> result 2: at cycle 1 with MDU_REUSE_EN, at cycle 33 without.
//   BITS_PER_CYCLE=4: MUL 7*-3 -> done at cycle 9.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M/RV64M multiply/divide unit beside the EX-stage ALU.
// Retires BITS_PER_CYCLE multiplier/quotient bits per cycle on magnitudes, then applies
// the sign fix when the result is registered. busy stalls IF/ID/EX; done is a one-cycle pulse.
// Optional build macro MDU_REUSE_EN: a DIV/REM (or DIVU/REMU) that follows a full-length divide
// with the same operands and signedness is answered from stored quotient/remainder in one cycle.
module ex_muldiv_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            Rst,
    input  logic            dbg,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);
    localparam int ITER = XLEN / BITS_PER_CYCLE;
    localparam int CW   = $clog2(ITER + 1);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]   cnt;
    logic [2:0]      op_q;
    logic [4:0]      rd_q, rd_held;
    logic            na_q, nq_q;     // sign of a (remainder), sign of product/quotient
    logic [XLEN-1:0] hi_q, lo_q, mcand_q, res_q, res_held;

    logic            a_neg, b_neg, early, hit, fast, launch, last;
    logic [XLEN-1:0] a_mag, b_mag, early_res, hit_res, fast_res;

    // Operand decode: signedness per funct3, magnitudes, and single-cycle answers
    assign a_neg     = a[XLEN-1] & (op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd6);
    assign b_neg     = b[XLEN-1] & (op == 3'd1 || op == 3'd4 || op == 3'd6);
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;
    assign early     = op[2] & ((b == '0) | (~op[0] & (a == MIN) & (b == '1)));
    assign early_res = (b == '0) ? (op[1] ? a : '1) : (op[1] ? '0 : MIN);
    assign fast      = early | hit;
    assign fast_res  = early ? early_res : hit_res;
    assign launch    = (state == IDLE) & start & ~flush;
    assign last      = (state == RUN) & (cnt == CW'(1));

    logic [XLEN-1:0]   hi_s, lo_s;
    logic [XLEN:0]     r;
    // One iteration group: shift-add multiply (multiplier in lo) or restoring divide (dividend in lo)
    always_comb begin
        hi_s = hi_q;
        lo_s = lo_q;
        r    = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (op_q[2]) begin
                r    = {hi_s, lo_s[XLEN-1]};
                lo_s = lo_s << 1;
                if (r >= {1'b0, mcand_q}) begin
                    r       = r - {1'b0, mcand_q};
                    lo_s[0] = 1'b1;
                end
                hi_s = r[XLEN-1:0];
            end else begin
                r    = {1'b0, hi_s} + (lo_s[0] ? {1'b0, mcand_q} : '0);
                lo_s = {r[0], lo_s[XLEN-1:1]};
                hi_s = r[XLEN:1];
            end
        end
    end

    logic [2*XLEN-1:0] prod_f;
    logic [XLEN-1:0]   q_f, r_f, fin_res;
    // Sign fix applied to the post-step values so the final step and fix share one edge
    always_comb begin
        prod_f  = nq_q ? -{hi_s, lo_s} : {hi_s, lo_s};
        q_f     = nq_q ? -lo_s : lo_s;
        r_f     = na_q ? -hi_s : hi_s;
        fin_res = op_q[2] ? (op_q[1] ? r_f : q_f)
                          : ((op_q == 3'd0) ? prod_f[XLEN-1:0] : prod_f[2*XLEN-1:XLEN]);
    end

    // State register; dbg freezes the FSM
    always_ff @(posedge clk) begin
        if (Rst)       state <= IDLE;
        else if (!dbg) state <= state_nxt;
    end

    // Next state: fast ops skip RUN, flush aborts RUN/FIN
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = fast ? FIN : RUN;
            RUN:     if (flush) state_nxt = IDLE;
                     else if (cnt == CW'(1)) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath, counter and held outputs; the held copy only updates on an unflushed done
    always_ff @(posedge clk) begin
        if (Rst) begin
            cnt      <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            rd_held  <= '0;
            na_q     <= 1'b0;
            nq_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            mcand_q  <= '0;
            res_q    <= '0;
            res_held <= '0;
        end else if (!dbg) begin
            if (launch) begin
                op_q    <= op;
                rd_q    <= rd_in;
                na_q    <= a_neg;
                nq_q    <= a_neg ^ b_neg;
                hi_q    <= '0;
                lo_q    <= a_mag;
                mcand_q <= b_mag;
                cnt     <= fast ? '0 : CW'(ITER);
                if (fast) res_q <= fast_res;
            end else if (state == RUN && !flush) begin
                hi_q <= hi_s;
                lo_q <= lo_s;
                cnt  <= cnt - CW'(1);
                if (last) res_q <= fin_res;
            end else if (state == FIN && !flush) begin
                res_held <= res_q;
                rd_held  <= rd_q;
            end
        end
    end

    // done is suppressed by a same-cycle flush (unless frozen) so result/rd_out keep old values
    assign busy   = (state == RUN);
    assign done   = (state == FIN) & ~Rst & (dbg | ~flush);
    assign result = done ? res_q : res_held;
    assign rd_out = done ? rd_q : rd_held;

`ifdef MDU_REUSE_EN
    logic            ru_vld, ru_sgn, full_q;
    logic [XLEN-1:0] ru_a, ru_b, ru_q, ru_r;

    assign hit     = op[2] & ru_vld & (a == ru_a) & (b == ru_b) & (ru_sgn == ~op[0]);
    assign hit_res = op[1] ? ru_r : ru_q;

    // Reuse store: operands at launch, both results at the last step, valid on completion
    always_ff @(posedge clk) begin
        if (Rst) begin
            ru_vld <= 1'b0;
            ru_sgn <= 1'b0;
            full_q <= 1'b0;
            ru_a   <= '0;
            ru_b   <= '0;
            ru_q   <= '0;
            ru_r   <= '0;
        end else if (!dbg) begin
            if (launch) begin
                full_q <= ~fast;
                if (op[2] & ~fast) begin
                    ru_a   <= a;
                    ru_b   <= b;
                    ru_sgn <= ~op[0];
                    ru_vld <= 1'b0;
                end
            end
            if (last & op_q[2]) begin
                ru_q <= q_f;
                ru_r <= r_f;
            end
            if (state != IDLE && flush && op_q[2]) ru_vld <= 1'b0;
            else if (state == FIN && !flush) begin
                if (!op_q[2])    ru_vld <= 1'b0;
                else if (full_q) ru_vld <= 1'b1;
            end
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_res = '0;
`endif

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: scoreboard bench for ex_muldiv_unit (XLEN=32, one bit per cycle).
module tb_ex_muldiv_unit;
    localparam int XLEN = 32;
    localparam int BPC  = 1;
    localparam int ITER = XLEN / BPC;
    localparam logic [31:0] MIN = 32'h8000_0000;

    logic            clk = 1'b0;
    logic            Rst, dbg, flush, start;
    logic [2:0]      op;
    logic [XLEN-1:0] a, b;
    logic [4:0]      rd_in;
    logic            busy, done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0, fails = 0, cyc = 0;
    logic [31:0] last_res = '0;
    bit          ru_vld = 1'b0, ru_sgn = 1'b0;
    logic [31:0] ru_a = '0, ru_b = '0;

    ex_muldiv_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(BPC)) dut (
        .clk(clk), .Rst(Rst), .dbg(dbg), .flush(flush), .start(start), .op(op),
        .a(a), .b(b), .rd_in(rd_in), .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: RISC-V M semantics via 64-bit integer arithmetic
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint          sx = longint'($signed(x));
        longint          sy = longint'($signed(y));
        longint unsigned ux = {32'b0, x};
        longint unsigned uy = {32'b0, y};
        logic [63:0]     p;
        case (f)
            3'd0: begin p = ux * uy; return p[31:0];  end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * longint'(uy); return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin if (y == 0) return '1; p = sx / sy; return p[31:0]; end
            3'd5: begin if (y == 0) return '1; p = ux / uy; return p[31:0]; end
            3'd6: begin if (y == 0) return x;  p = sx % sy; return p[31:0]; end
            default: begin if (y == 0) return x; p = ux % uy; return p[31:0]; end
        endcase
    endfunction

    function automatic bit is_early(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        return f[2] && (y == 0 || (!f[0] && x == MIN && y == 32'hFFFF_FFFF));
    endfunction

    function automatic bit is_hit(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        return f[2] && ru_vld && x == ru_a && y == ru_b && ru_sgn == !f[0];
    endfunction

    function automatic int latency(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (is_early(f, x, y)) return 1;
`ifdef MDU_REUSE_EN
        if (is_hit(f, x, y)) return 1;
`endif
        return ITER + 1;
    endfunction

    // Scoreboard monitor: every done must match the oldest expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (done) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: actual result 0x%0h required no done (cycle %0d)", result, cyc);
            end else begin
                e = exp_q.pop_front();
                check("result", result, e.res);
                check("rd_out", rd_out, e.rd);
                check("done_cycle", cyc, e.cyc);
                last_res = e.res;
            end
        end
    end

    // Drive one start pulse; returns in cycle 1 of the op
    task automatic issue_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] want, input bit track, input int extra,
                            output int c0, output int lat);
        exp_t        e;
        logic [4:0]  r;
        r = 5'($urandom_range(0, 31));
        @(posedge clk); #1;
        lat = latency(f, x, y);
        c0  = cyc;
        if (track) begin
            e.res = want; e.rd = r; e.cyc = c0 + lat + extra;
            exp_q.push_back(e);
            if (!f[2]) ru_vld = 1'b0;
            else if (!is_early(f, x, y) && !is_hit(f, x, y)) begin
                ru_a = x; ru_b = y; ru_sgn = !f[0]; ru_vld = 1'b1;
            end
        end
        start = 1'b1; op = f; a = x; b = y; rd_in = r;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_done(output int nbusy, output bit seen);
        nbusy = 0;
        seen  = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: actual no done required done (cycle %0d)", cyc);
            exp_q.delete();
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input logic [31:0] want);
        int c0, lat, nb;
        bit seen;
        issue_op(f, x, y, want, 1'b1, 0, c0, lat);
        wait_done(nb, seen);
        if (seen) check("busy_cycles", nb, lat - 1);
    endtask

    initial begin
        int          c0, lat, nb;
        bit          seen;
        logic [2:0]  pf;
        logic [31:0] pa, pb;
        Rst = 1'b1; dbg = 1'b0; flush = 1'b0; start = 1'b0;
        op = '0; a = '0; b = '0; rd_in = '0;
        pf = '0; pa = '0; pb = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        check("reset_rd_out", rd_out, 0);
        Rst = 1'b0;

        // directed values
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        run_op(3'd5, 32'd100, 32'd7, 32'd14);
        run_op(3'd7, 32'd100, 32'd7, 32'd2);
        run_op(3'd4, -32'sd100, 32'd7, 32'hFFFF_FFF2);
        run_op(3'd6, -32'sd100, 32'd7, 32'hFFFF_FFFE);
        run_op(3'd4, 32'd12345, 32'd0, 32'hFFFF_FFFF);
        run_op(3'd6, 32'd5, 32'd0, 32'd5);
        run_op(3'd4, MIN, 32'hFFFF_FFFF, MIN);
        run_op(3'd6, MIN, 32'hFFFF_FFFF, 32'd0);
        run_op(3'd0, 32'd3, 32'd5, 32'd15);
        run_op(3'd4, 32'd100, 32'd7, 32'd14);
        run_op(3'd6, 32'd100, 32'd7, 32'd2);

        // randomized ops against the model, with repeats to reach the reuse path
        for (int n = 0; n < 60; n++) begin
            logic [2:0]  f;
            logic [31:0] x, y;
            int          sel;
            f   = 3'($urandom_range(0, 7));
            x   = $urandom;
            y   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) y = '0;
            else if (sel == 1) begin x = MIN; y = '1; end
            else if (sel < 4) y = 32'($urandom_range(1, 100));
            else if (sel < 6 && pf[2]) begin x = pa; y = pb; f = pf ^ 3'd2; end
            run_op(f, x, y, model(f, x, y));
            pf = f; pa = x; pb = y;
        end

        // freeze cycles 5..9 delays done by five cycles
        issue_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1, 5, c0, lat);
        while (cyc < c0 + 5) begin @(posedge clk); #1; end
        dbg = 1'b1;
        while (cyc < c0 + 10) begin @(posedge clk); #1; end
        dbg = 1'b0;
        wait_done(nb, seen);

        // flush at cycle 10 of a divide: no done, result unchanged
        issue_op(3'd4, 32'd1000, 32'd3, 32'd0, 1'b0, 0, c0, lat);
        while (cyc < c0 + 10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_result", result, last_res);
        repeat (40) @(posedge clk);
        ru_vld = 1'b0;
        run_op(3'd5, 32'd1000, 32'd3, 32'd333);

        // reset at cycle 20 of a multiply clears all outputs
        issue_op(3'd0, 32'd9, 32'd9, 32'd0, 1'b0, 0, c0, lat);
        while (cyc < c0 + 20) begin @(posedge clk); #1; end
        Rst = 1'b1;
        @(posedge clk); #1;
        Rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_rd_out", rd_out, 0);
        ru_vld = 1'b0;
        last_res = '0;
        repeat (40) @(posedge clk);
        run_op(3'd7, 32'd1000, 32'd3, 32'd1);

        repeat (5) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
